switch_driver: RTL and testbench

SWITCH_DRIVER -- requirements
Module: switch_driver

---
 rtl/switch_driver_if.sv | 23 ++
 rtl/switch_driver.sv | 111 +++++++++++
 tb/tb_switch_driver.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/switch_driver_if.sv
// Host-side command/result handshake bundle for switch_driver.
interface switch_driver_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_weight;
    logic       cmd_fwd;
    logic       cmd_offset;
    logic       cmd_op;
    logic [5:0] cmd_operand;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;

    modport master (
        output cmd_valid, cmd_weight, cmd_fwd, cmd_offset, cmd_op, cmd_operand, res_ready,
        input  cmd_ready, res_valid, res_data
    );

    modport slave (
        input  cmd_valid, cmd_weight, cmd_fwd, cmd_offset, cmd_op, cmd_operand, res_ready,
        output cmd_ready, res_valid, res_data
    );
endinterface

// File: rtl/switch_driver.sv
// Purpose: serialises one host command into WEIGHT/NEXT/START/END tile bytes and captures the tile result.
// Latency: res_valid rises RESULT_LAT+2 edges after the accepting edge (local compute only).
// Backpressure: one command in flight; cmd_ready only in IDLE, RESP holds until res_ready.
module switch_driver #(
    parameter int RESULT_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    switch_driver_if.slave host,
    output logic [7:0]     switch_data_out,
    input  logic [7:0]     switch_data_in,
    output logic           busy
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_WEIGHT, ST_NEXT, ST_START, ST_WAIT, ST_END, ST_RESP
    } state_t;

    localparam logic [3:0] WAIT_LAST = (RESULT_LAT > 1) ? 4'(RESULT_LAT - 2) : 4'd0;

    state_t     state, state_nxt;
    logic [3:0] weight_reg;
    logic       fwd_reg, offset_reg, op_reg;
    logic [5:0] operand_reg;
    logic [3:0] cnt, cnt_nxt;
    logic [7:0] res_data_reg;
    logic       res_valid_reg;
    logic [7:0] sdo_reg, sdo_nxt;
    logic       accept, capture;

    assign accept = (state == ST_IDLE) && host.cmd_valid;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_WEIGHT;
            ST_WEIGHT: state_nxt = fwd_reg ? ST_NEXT : ST_START;
            ST_NEXT:   state_nxt = ST_START;
            ST_START: begin
                // With a one-cycle tile latency the result is ready as START ends, so WAIT is skipped.
                if (fwd_reg) begin
                    state_nxt = ST_END;
                end else if (RESULT_LAT == 1) begin
                    capture   = 1'b1;
                    state_nxt = ST_END;
                end else begin
                    cnt_nxt   = 4'd0;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    capture   = 1'b1;
                    state_nxt = ST_END;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            ST_END:  state_nxt = fwd_reg ? ST_IDLE : ST_RESP;
            ST_RESP: if (host.res_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The output byte is registered from the next state, so it lines up with the state it belongs to.
    always_comb begin
        sdo_nxt = {4'b0000, weight_reg};
        case (state_nxt)
            ST_WEIGHT:        sdo_nxt = {4'b0000, host.cmd_weight};
            ST_NEXT:          sdo_nxt = {2'b01, 1'b0, offset_reg, 3'b000, op_reg};
            ST_START, ST_WAIT: sdo_nxt = {2'b10, operand_reg};
            ST_END:           sdo_nxt = 8'hC0;
            default:          sdo_nxt = {4'b0000, weight_reg};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            weight_reg    <= 4'd0;
            fwd_reg       <= 1'b0;
            offset_reg    <= 1'b0;
            op_reg        <= 1'b0;
            operand_reg   <= 6'd0;
            cnt           <= 4'd0;
            res_data_reg  <= 8'd0;
            res_valid_reg <= 1'b0;
            sdo_reg       <= 8'd0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            sdo_reg       <= sdo_nxt;
            res_valid_reg <= (state_nxt == ST_RESP);
            if (accept) begin
                weight_reg  <= host.cmd_weight;
                fwd_reg     <= host.cmd_fwd;
                offset_reg  <= host.cmd_offset;
                op_reg      <= host.cmd_op;
                operand_reg <= host.cmd_operand;
            end
            if (capture) res_data_reg <= switch_data_in;
        end
    end

    assign host.cmd_ready = (state == ST_IDLE);
    assign busy           = (state != ST_IDLE);
    assign host.res_valid = res_valid_reg;
    assign host.res_data  = res_data_reg;
    assign switch_data_out = sdo_reg;
endmodule

// File: tb/tb_switch_driver.sv
// Directed bench for switch_driver: main instance at RESULT_LAT=2 plus 1 and 15 builds for the capture edge.
module tb_switch_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    switch_driver_if h();
    switch_driver_if h1();
    switch_driver_if h15();
    logic [7:0] sdo, sdo1, sdo15;
    logic [7:0] din, din1, din15;
    logic       busy, busy1, busy15;

    switch_driver #(.RESULT_LAT(2))  dut   (.clk(clk), .rst(rst), .host(h),   .switch_data_out(sdo),   .switch_data_in(din),   .busy(busy));
    switch_driver #(.RESULT_LAT(1))  dut1  (.clk(clk), .rst(rst), .host(h1),  .switch_data_out(sdo1),  .switch_data_in(din1),  .busy(busy1));
    switch_driver #(.RESULT_LAT(15)) dut15 (.clk(clk), .rst(rst), .host(h15), .switch_data_out(sdo15), .switch_data_in(din15), .busy(busy15));

    int n_cmp = 0;
    int n_err = 0;

    // Inputs are driven and outputs sampled on the falling edge, away from the active edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_cmd(input logic [3:0] w, input logic f, input logic o, input logic p, input logic [5:0] opd);
        h.cmd_weight = w; h.cmd_fwd = f; h.cmd_offset = o; h.cmd_op = p; h.cmd_operand = opd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_cmp++; if (sdo !== 8'h00) begin n_err++; $display("FAIL rst_hold_sdo got %h want 00", sdo); end
        rst = 1'b0;
        step();
        n_cmp++; if (h.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready got %b want 1", h.cmd_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (h.res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid got %b want 0", h.res_valid); end
        n_cmp++; if (h.res_data !== 8'h00) begin n_err++; $display("FAIL rst_res_data got %h want 00", h.res_data); end
        n_cmp++; if (sdo !== 8'h00) begin n_err++; $display("FAIL rst_sdo got %h want 00", sdo); end
    endtask

    task automatic test_local_compute();
        set_cmd(4'd5, 1'b0, 1'b0, 1'b0, 6'h0A);
        din = 8'hEE; h.res_ready = 1'b0; h.cmd_valid = 1'b1;
        n_cmp++; if (h.cmd_ready !== 1'b1) begin n_err++; $display("FAIL loc_ready_pre got %b want 1", h.cmd_ready); end
        step();
        h.cmd_valid = 1'b0;
        n_cmp++; if (sdo !== 8'h05) begin n_err++; $display("FAIL loc_weight got %h want 05", sdo); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL loc_busy got %b want 1", busy); end
        n_cmp++; if (h.cmd_ready !== 1'b0) begin n_err++; $display("FAIL loc_ready_busy got %b want 0", h.cmd_ready); end
        step();
        n_cmp++; if (sdo !== 8'h8A) begin n_err++; $display("FAIL loc_start got %h want 8a", sdo); end
        step();
        // Only the value present during the single WAIT cycle may be captured.
        din = 8'h2F;
        n_cmp++; if (sdo !== 8'h8A) begin n_err++; $display("FAIL loc_wait got %h want 8a", sdo); end
        n_cmp++; if (h.res_valid !== 1'b0) begin n_err++; $display("FAIL loc_wait_valid got %b want 0", h.res_valid); end
        step();
        din = 8'hEE;
        n_cmp++; if (sdo !== 8'hC0) begin n_err++; $display("FAIL loc_end got %h want c0", sdo); end
        n_cmp++; if (h.res_valid !== 1'b0) begin n_err++; $display("FAIL loc_end_valid got %b want 0", h.res_valid); end
        step();
        n_cmp++; if (h.res_valid !== 1'b1) begin n_err++; $display("FAIL loc_resp_valid got %b want 1", h.res_valid); end
        n_cmp++; if (h.res_data !== 8'h2F) begin n_err++; $display("FAIL loc_resp_data got %h want 2f", h.res_data); end
        n_cmp++; if (sdo !== 8'h05) begin n_err++; $display("FAIL loc_resp_sdo got %h want 05", sdo); end
        h.res_ready = 1'b1;
        step();
        h.res_ready = 1'b0;
        n_cmp++; if (h.res_valid !== 1'b0) begin n_err++; $display("FAIL loc_done_valid got %b want 0", h.res_valid); end
        n_cmp++; if (h.cmd_ready !== 1'b1) begin n_err++; $display("FAIL loc_done_ready got %b want 1", h.cmd_ready); end
    endtask

    task automatic test_backpressure();
        set_cmd(4'd9, 1'b0, 1'b0, 1'b0, 6'h3C);
        din = 8'h77; h.res_ready = 1'b0; h.cmd_valid = 1'b1;
        step();
        h.cmd_valid = 1'b0;
        step(); step(); step(); step();
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (h.res_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d] got %b want 1", i, h.res_valid); end
            n_cmp++; if (h.res_data !== 8'h77) begin n_err++; $display("FAIL bp_data[%0d] got %h want 77", i, h.res_data); end
            n_cmp++; if (h.cmd_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d] got %b want 0", i, h.cmd_ready); end
            din = 8'(i);
            step();
        end
        n_cmp++; if (h.res_valid !== 1'b1) begin n_err++; $display("FAIL bp_still_valid got %b want 1", h.res_valid); end
        h.res_ready = 1'b1;
        step();
        h.res_ready = 1'b0;
        n_cmp++; if (h.cmd_ready !== 1'b1) begin n_err++; $display("FAIL bp_idle_ready got %b want 1", h.cmd_ready); end
        n_cmp++; if (h.res_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle_valid got %b want 0", h.res_valid); end
        n_cmp++; if (h.res_data !== 8'h77) begin n_err++; $display("FAIL bp_idle_data got %h want 77", h.res_data); end
    endtask

    task automatic test_forward();
        logic [7:0] exp_bytes [4];
        exp_bytes = '{8'h03, 8'h51, 8'h91, 8'hC0};
        set_cmd(4'd3, 1'b1, 1'b1, 1'b1, 6'h11);
        din = 8'h99; h.res_ready = 1'b1; h.cmd_valid = 1'b1;
        step();
        h.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (sdo !== exp_bytes[i]) begin n_err++; $display("FAIL fwd_byte[%0d] got %h want %h", i, sdo, exp_bytes[i]); end
            n_cmp++; if (h.res_valid !== 1'b0) begin n_err++; $display("FAIL fwd_valid[%0d] got %b want 0", i, h.res_valid); end
            step();
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fwd_idle_busy got %b want 0", busy); end
        n_cmp++; if (h.res_valid !== 1'b0) begin n_err++; $display("FAIL fwd_idle_valid got %b want 0", h.res_valid); end
        n_cmp++; if (h.res_data !== 8'h77) begin n_err++; $display("FAIL fwd_res_data got %h want 77", h.res_data); end
        n_cmp++; if (sdo !== 8'h03) begin n_err++; $display("FAIL fwd_idle_sdo got %h want 03", sdo); end
        h.res_ready = 1'b0;
        set_cmd(4'd0, 1'b0, 1'b0, 1'b0, 6'h00);
    endtask

    task automatic test_reset_mid_wait();
        set_cmd(4'd6, 1'b0, 1'b0, 1'b0, 6'h05);
        din = 8'h33; h.cmd_valid = 1'b1;
        step();
        h.cmd_valid = 1'b0;
        step(); step();
        n_cmp++; if (sdo !== 8'h85) begin n_err++; $display("FAIL rmw_wait_sdo got %h want 85", sdo); end
        rst = 1'b1; h.cmd_valid = 1'b1; h.res_ready = 1'b1;
        step();
        h.cmd_valid = 1'b0; h.res_ready = 1'b0;
        n_cmp++; if (sdo !== 8'h00) begin n_err++; $display("FAIL rmw_sdo got %h want 00", sdo); end
        n_cmp++; if (h.res_valid !== 1'b0) begin n_err++; $display("FAIL rmw_valid got %b want 0", h.res_valid); end
        n_cmp++; if (h.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rmw_ready got %b want 1", h.cmd_ready); end
        n_cmp++; if (h.res_data !== 8'h00) begin n_err++; $display("FAIL rmw_data got %h want 00", h.res_data); end
        rst = 1'b0;
        step();
        n_cmp++; if (sdo !== 8'h00) begin n_err++; $display("FAIL rmw_release_sdo got %h want 00", sdo); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmw_release_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        set_cmd(4'd1, 1'b0, 1'b0, 1'b0, 6'h01);
        din = 8'h5A; h.res_ready = 1'b1; h.cmd_valid = 1'b1;
        step();
        // Second command waits on the bus while the first runs.
        set_cmd(4'd2, 1'b0, 1'b0, 1'b0, 6'h02);
        n_cmp++; if (sdo !== 8'h01) begin n_err++; $display("FAIL b2b_a_weight got %h want 01", sdo); end
        step();
        n_cmp++; if (sdo !== 8'h81) begin n_err++; $display("FAIL b2b_a_start got %h want 81", sdo); end
        step(); step(); step();
        n_cmp++; if (h.res_valid !== 1'b1) begin n_err++; $display("FAIL b2b_a_valid got %b want 1", h.res_valid); end
        n_cmp++; if (h.res_data !== 8'h5A) begin n_err++; $display("FAIL b2b_a_data got %h want 5a", h.res_data); end
        din = 8'hA5;
        step();
        n_cmp++; if (h.cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle_ready got %b want 1", h.cmd_ready); end
        n_cmp++; if (sdo !== 8'h01) begin n_err++; $display("FAIL b2b_idle_sdo got %h want 01", sdo); end
        step();
        h.cmd_valid = 1'b0;
        n_cmp++; if (sdo !== 8'h02) begin n_err++; $display("FAIL b2b_b_weight got %h want 02", sdo); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_b_busy got %b want 1", busy); end
        step();
        n_cmp++; if (sdo !== 8'h82) begin n_err++; $display("FAIL b2b_b_start got %h want 82", sdo); end
        step(); step(); step();
        n_cmp++; if (h.res_valid !== 1'b1) begin n_err++; $display("FAIL b2b_b_valid got %b want 1", h.res_valid); end
        n_cmp++; if (h.res_data !== 8'hA5) begin n_err++; $display("FAIL b2b_b_data got %h want a5", h.res_data); end
        step();
        h.res_ready = 1'b0;
        n_cmp++; if (h.cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_end_ready got %b want 1", h.cmd_ready); end
    endtask

    task automatic test_lat_extremes();
        int seen1, seen15;
        logic [7:0] rd1, rd15, s1_k1, s1_k2, s15_k15, s15_k16;
        seen1 = -1; seen15 = -1;
        rd1 = 8'h00; rd15 = 8'h00; s1_k1 = 8'h00; s1_k2 = 8'h00; s15_k15 = 8'h00; s15_k16 = 8'h00;
        h1.cmd_weight = 4'd7;  h1.cmd_fwd = 1'b0;  h1.cmd_offset = 1'b0;  h1.cmd_op = 1'b0;  h1.cmd_operand = 6'h2A;
        h15.cmd_weight = 4'd7; h15.cmd_fwd = 1'b0; h15.cmd_offset = 1'b0; h15.cmd_op = 1'b0; h15.cmd_operand = 6'h2A;
        h1.res_ready = 1'b0; h15.res_ready = 1'b0;
        h1.cmd_valid = 1'b1; h15.cmd_valid = 1'b1;
        step();
        h1.cmd_valid = 1'b0; h15.cmd_valid = 1'b0;
        din1 = 8'h40; din15 = 8'h40;
        // After the k-th edge past acceptance the tile drives 0x40+k.
        for (int k = 1; k <= 30; k++) begin
            step();
            if (seen1 < 0 && h1.res_valid === 1'b1) begin seen1 = k; rd1 = h1.res_data; end
            if (seen15 < 0 && h15.res_valid === 1'b1) begin seen15 = k; rd15 = h15.res_data; end
            if (k == 1) s1_k1 = sdo1;
            if (k == 2) s1_k2 = sdo1;
            if (k == 15) s15_k15 = sdo15;
            if (k == 16) s15_k16 = sdo15;
            din1 = 8'(8'h40 + k); din15 = 8'(8'h40 + k);
        end
        n_cmp++; if (seen1 !== 3) begin n_err++; $display("FAIL lat1_valid_edge got %0d want 3", seen1); end
        n_cmp++; if (rd1 !== 8'h41) begin n_err++; $display("FAIL lat1_data got %h want 41", rd1); end
        n_cmp++; if (s1_k1 !== 8'hAA) begin n_err++; $display("FAIL lat1_start got %h want aa", s1_k1); end
        n_cmp++; if (s1_k2 !== 8'hC0) begin n_err++; $display("FAIL lat1_end got %h want c0", s1_k2); end
        n_cmp++; if (seen15 !== 17) begin n_err++; $display("FAIL lat15_valid_edge got %0d want 17", seen15); end
        n_cmp++; if (rd15 !== 8'h4F) begin n_err++; $display("FAIL lat15_data got %h want 4f", rd15); end
        n_cmp++; if (s15_k15 !== 8'hAA) begin n_err++; $display("FAIL lat15_last_wait got %h want aa", s15_k15); end
        n_cmp++; if (s15_k16 !== 8'hC0) begin n_err++; $display("FAIL lat15_end got %h want c0", s15_k16); end
    endtask

    initial begin
        h.cmd_valid = 1'b0; h.res_ready = 1'b0;
        h1.cmd_valid = 1'b0; h1.res_ready = 1'b0;
        h15.cmd_valid = 1'b0; h15.res_ready = 1'b0;
        set_cmd(4'd0, 1'b0, 1'b0, 1'b0, 6'h00);
        h1.cmd_weight = 4'd0; h1.cmd_fwd = 1'b0; h1.cmd_offset = 1'b0; h1.cmd_op = 1'b0; h1.cmd_operand = 6'h00;
        h15.cmd_weight = 4'd0; h15.cmd_fwd = 1'b0; h15.cmd_offset = 1'b0; h15.cmd_op = 1'b0; h15.cmd_operand = 6'h00;
        din = 8'h00; din1 = 8'h00; din15 = 8'h00;
        @(negedge clk);
        test_reset();
        test_local_compute();
        test_backpressure();
        test_forward();
        test_reset_mid_wait();
        test_back_to_back();
        test_lat_extremes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
